// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR datapath blocks.
package fir_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_N_TAPS = 16;

  typedef logic [DEFAULT_WIDTH-1:0] probka_t;

  typedef enum logic {
    CZYSC  = 1'b0,
    GOTOWY = 1'b1
  } stan_t;

endpackage

// File: rtl/licznik_petli.sv
// Saturating tap-loop counter; reset_petla beats petla_en, outputs are registered
// copies of the next-state index so they move together with it.
module licznik_petli #(
  parameter int N_TAPS = 16,
  parameter int IDX_W  = $clog2(N_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             petla_en,
  input  logic             reset_petla,
  output logic [IDX_W-1:0] wsp_adr,
  output logic             petla_full
);

  localparam logic [IDX_W-1:0] OSTATNI = IDX_W'(N_TAPS - 1);

  logic [IDX_W-1:0] k_nast;

  always_comb begin
    k_nast = wsp_adr;
    if (reset_petla) begin
      k_nast = '0;
    end else if (petla_en && (wsp_adr != OSTATNI)) begin
      k_nast = wsp_adr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsp_adr    <= '0;
      petla_full <= 1'b0;
    end else begin
      wsp_adr    <= k_nast;
      petla_full <= (k_nast == OSTATNI);
    end
  end

endmodule

// File: rtl/fir_linia_opozniajaca.sv
// Circular sample delay line: stores the last N_TAPS samples and replays them
// newest first, one per tap, with a zero-fill engine that clears the line.
module fir_linia_opozniajaca
  import fir_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int N_TAPS = DEFAULT_N_TAPS,
  parameter int IDX_W  = $clog2(N_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] probka_wej,
  input  logic             FSM_nowa_shift,
  input  logic             FSM_reset_shift,
  input  logic             FSM_petla_en,
  input  logic             FSM_reset_petla,
  output logic [WIDTH-1:0] probka_out,
  output logic [IDX_W-1:0] wsp_adr,
  output logic             Petla_full,
  output logic             zajety,
  output logic             zgubiona
);

  localparam logic [IDX_W-1:0] OSTATNI = IDX_W'(N_TAPS - 1);
  localparam logic [IDX_W:0]   N_EXT   = (IDX_W + 1)'(N_TAPS);

  stan_t            stan, stan_nast;
  logic [IDX_W-1:0] wr_ptr, wr_ptr_nast, fill_cnt, rd_adr;
  logic [IDX_W:0]   roznica;
  logic [WIDTH-1:0] mem [N_TAPS];
  logic             zapis_ok, zapis_stracony;
  logic             mem_we;
  logic [IDX_W-1:0] mem_adr;
  logic [WIDTH-1:0] mem_dane;

  licznik_petli #(
    .N_TAPS(N_TAPS),
    .IDX_W (IDX_W)
  ) u_licznik (
    .clk        (clk),
    .rst_n      (rst_n),
    .petla_en   (FSM_petla_en),
    .reset_petla(FSM_reset_petla),
    .wsp_adr    (wsp_adr),
    .petla_full (Petla_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stan <= CZYSC;
    end else begin
      stan <= stan_nast;
    end
  end

  always_comb begin
    stan_nast = stan;
    case (stan)
      CZYSC:   if (!FSM_reset_shift && (fill_cnt == OSTATNI)) stan_nast = GOTOWY;
      GOTOWY:  if (FSM_reset_shift) stan_nast = CZYSC;
      default: stan_nast = CZYSC;
    endcase
  end

  // A fill request in the same cycle as a write wins, so that sample is lost too.
  always_comb begin
    zajety         = (stan == CZYSC);
    zapis_ok       = (stan == GOTOWY) && FSM_nowa_shift && !FSM_reset_shift;
    zapis_stracony = FSM_nowa_shift && ((stan == CZYSC) || FSM_reset_shift);
    wr_ptr_nast    = (wr_ptr == OSTATNI) ? '0 : wr_ptr + 1'b1;
    mem_we         = zajety || zapis_ok;
    mem_adr        = zajety ? fill_cnt : wr_ptr_nast;
    mem_dane       = zajety ? '0 : probka_wej;
  end

  // Tap address wraps via a borrow check instead of a modulo, so any N_TAPS works.
  always_comb begin
    roznica = {1'b0, wr_ptr} - {1'b0, wsp_adr};
    if (roznica[IDX_W]) begin
      roznica = roznica + N_EXT;
    end
    rd_adr = roznica[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_adr] <= mem_dane;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= OSTATNI;
      fill_cnt   <= '0;
      zgubiona   <= 1'b0;
      probka_out <= '0;
    end else begin
      if (FSM_reset_shift || (stan == GOTOWY) || (fill_cnt == OSTATNI)) begin
        fill_cnt <= '0;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (FSM_reset_shift) begin
        wr_ptr <= OSTATNI;
      end else if (zapis_ok) begin
        wr_ptr <= wr_ptr_nast;
      end
      if (zapis_stracony) begin
        zgubiona <= 1'b1;
      end
      probka_out <= zajety ? '0 : mem[rd_adr];
    end
  end

endmodule

// File: doc/fir_linia_opozniajaca.md
Name: fir_linia_opozniajaca

Overview:
- Circular sample delay line for the FIR datapath.
- Sits directly upstream of the multiplier that feeds the adder.
- Stores the last N_TAPS input samples and, under FSM control, presents them one per tap, newest first, together with the matching coefficient index.
- Owns the tap-loop counter and drives Petla_full back to fsm.

Parameters:
- WIDTH, 16, sample width in bits.
- N_TAPS, 16, number of taps and stored samples; legal range is 2 or more; need not be a power of two.
- IDX_W, $clog2(N_TAPS), width of the pointer and tap index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- probka_wej  in  WIDTH  new input sample.
- FSM_nowa_shift  in  1  pulse: write probka_wej as the newest sample.
- FSM_reset_shift  in  1  pulse: start a zero-fill of the whole line.
- FSM_petla_en  in  1  advance the tap index.
- FSM_reset_petla  in  1  tap index to 0.
- probka_out  out  WIDTH  sample for the current tap; registered.
- wsp_adr  out  IDX_W  coefficient address, equal to the current tap index.
- Petla_full  out  1  registered; 1 when tap index == N_TAPS-1.
- zajety  out  1  1 while a zero-fill is in progress.
- zgubiona  out  1  sticky: a write was dropped during a fill.

Behaviour:
- State: mem[N_TAPS], wr_ptr (newest sample), k (tap index), fill counter, fill state.
- FSM states: CZYSC and GOTOWY.
- rst_n=0 (synchronous):
  - k=0, wr_ptr=N_TAPS-1, fill counter=0, state=CZYSC.
  - Outputs: probka_out=0, wsp_adr=0, Petla_full=0, zajety=1, zgubiona=0.
  - mem has no reset; the fill clears it.
- CZYSC:
  - Writes 0 to mem[fill counter] each cycle for N_TAPS cycles.
  - After the write at address N_TAPS-1 the state moves to GOTOWY and zajety=0 on the next cycle.
  - Total zajety high time is exactly N_TAPS cycles after reset is released.
- FSM_reset_shift:
  - In GOTOWY it enters CZYSC with fill counter=0 and wr_ptr=N_TAPS-1.
  - During CZYSC it restarts the fill from 0.
  - k is not affected.
- Write, in GOTOWY with FSM_nowa_shift=1:
  - wr_ptr <= (wr_ptr+1) wrap N_TAPS.
  - mem[new wr_ptr] <= probka_wej.
- Write during CZYSC: dropped and zgubiona <= 1. zgubiona is cleared only by rst_n.
- FSM_reset_shift and FSM_nowa_shift in the same cycle: the fill wins and the sample is dropped (zgubiona=1).
- Tap index k:
  - FSM_reset_petla has priority: k <= 0.
  - Otherwise FSM_petla_en with k<N_TAPS-1: k <= k+1.
  - At N_TAPS-1, k saturates and holds; it never wraps.
  - Petla_full and wsp_adr are registered copies of the next-state k, so they change together with k.
- Read:
  - probka_out <= mem[(wr_ptr - k) wrap N_TAPS], computed from current-cycle wr_ptr and k.
  - One-cycle latency: data for tap k is valid the cycle after wsp_adr==k first appears.
  - The pointer subtraction is done in IDX_W+1 bits, adding N_TAPS on underflow; no modulo operator is used for non-power-of-two sizes.
- Write and read in the same cycle: the read uses the pre-write wr_ptr and mem contents (no bypass).
- probka_out reads 0 while zajety=1.
- No arithmetic on sample data; samples are passed through unchanged.

Decomposition:
- Shared package fir_pkg holds:
  - WIDTH and N_TAPS defaults.
  - typedef logic [WIDTH-1:0] probka_t.
  - The state enum {CZYSC, GOTOWY}.
- One sub-module, licznik_petli: the saturating tap counter with reset_petla priority, registered Petla_full and wsp_adr. fsm-side reuse is planned.

Test Plan (N_TAPS=4, WIDTH=16):
- Reset release: zajety=1 for exactly 4 cycles then 0; probka_out=0, Petla_full=0, zgubiona=0.
- Write 0x0011, 0x0022, 0x0033, 0x0044, then reset_petla and 3 petla_en pulses: probka_out sequence is 0x0044, 0x0033, 0x0022, 0x0011; Petla_full=1 with wsp_adr=3; a further petla_en holds k=3.
- Write a 5th sample 0x0055 (wr_ptr wraps), then sweep taps: outputs 0x0055, 0x0044, 0x0033, 0x0022.
- nowa_shift during zajety: sample dropped, zgubiona=1 and stays 1 after reset_shift; a later sweep reads all 0.
- petla_en and reset_petla together at k=2: k=0 and wsp_adr=0 next cycle.
- nowa_shift with the tap-0 read in the same cycle: the read returns the previous newest sample; the next read returns the new sample.
